key_debounce: RTL and testbench

- Receive-side conditioner for one physical panel key (run, water, open, reset, click), the input counterpart to the LED/7-segment output path.
- Synchronises the raw pin and rejects contact bounce.
- Emits clean level plus single-cycle press, release and long-press events for the state controller and the model.
- One instance per key, all on the divided system clock.

---
 rtl/key_debounce.sv | 186 ++++++++++++++++++
 tb/tb_key_debounce.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: receive-side conditioner for one panel key.
// A 2-flop synchroniser feeds a four-state debounce FSM that produces a
// clean level plus one-cycle press, release and long-press strobes.
// Optional auto-repeat strobe is enabled by defining KEY_AUTO_REPEAT_EN;
// without it repeat_pulse is tied low and no repeat counter exists.
module key_debounce #(
  parameter int DB_CNT     = 4,
  parameter int LONG_CNT   = 10,
  parameter int REPEAT_CNT = 5,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_key,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_CNT);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CNT);

  // Reject parameter sets the counters cannot represent.
  if (DB_CNT < 2 || LONG_CNT < 2 || REPEAT_CNT < 2 ||
      $clog2(DB_CNT + 1) > CNT_W || $clog2(LONG_CNT + 1) > CNT_W ||
      $clog2(REPEAT_CNT + 1) > CNT_W) begin : g_bad_param
    $error("key_debounce: count parameters must be >= 2 and fit in CNT_W bits");
  end

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state, state_next;
  logic             sync_p0, s_key;
  logic [CNT_W-1:0] db_cnt, db_next;
  logic [CNT_W-1:0] long_cnt, long_next;
  logic             level_next, press_next, release_next, long_pulse_next;

  // Stage p0/p1: two-flop synchroniser for the asynchronous key pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      s_key   <= 1'b0;
    end else begin
      sync_p0 <= in_key;
      s_key   <= sync_p0;
    end
  end

  // Debounce FSM next-state, counter and registered-output decode.
  always_comb begin
    state_next      = state;
    db_next         = db_cnt;
    long_next       = long_cnt;
    level_next      = key_level;
    press_next      = 1'b0;
    release_next    = 1'b0;
    long_pulse_next = 1'b0;
    case (state)
      IDLE: begin
        level_next = 1'b0;
        if (s_key) begin
          state_next = PRESS_WAIT;
          db_next    = CNT_W'(1);
        end else begin
          db_next    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_key) begin
          state_next = IDLE;
          db_next    = '0;
        end else if (db_cnt >= DB_MAX) begin
          state_next = HELD;
          db_next    = '0;
          long_next  = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          db_next    = sat_inc(db_cnt);
        end
      end
      HELD: begin
        level_next = 1'b1;
        if (!s_key) begin
          // long_cnt is frozen while the release is being qualified.
          state_next = RELEASE_WAIT;
          db_next    = CNT_W'(1);
        end else if (long_cnt < LONG_MAX) begin
          long_next       = sat_inc(long_cnt);
          long_pulse_next = (sat_inc(long_cnt) == LONG_MAX);
        end
      end
      RELEASE_WAIT: begin
        level_next = 1'b1;
        if (s_key) begin
          // Glitch on release: resume the hold without a new press event.
          state_next = HELD;
          db_next    = '0;
        end else if (db_cnt >= DB_MAX) begin
          state_next   = IDLE;
          db_next      = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          db_next      = sat_inc(db_cnt);
        end
      end
      default: begin
        state_next = IDLE;
        db_next    = '0;
        level_next = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      db_cnt        <= '0;
      long_cnt      <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_next;
      db_cnt        <= db_next;
      long_cnt      <= long_next;
      key_level     <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      long_pulse    <= long_pulse_next;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CNT);

  logic [CNT_W-1:0] rep_cnt, rep_next;
  logic             repeat_next;

  // Repeat counter runs only in HELD with the key down after long_pulse;
  // it pauses in RELEASE_WAIT and clears when the FSM heads to IDLE.
  always_comb begin
    rep_next    = rep_cnt;
    repeat_next = 1'b0;
    if (state == HELD && s_key && long_cnt == LONG_MAX) begin
      if (sat_inc(rep_cnt) >= REP_MAX) begin
        rep_next    = '0;
        repeat_next = 1'b1;
      end else begin
        rep_next    = sat_inc(rep_cnt);
      end
    end else if (state_next == IDLE) begin
      rep_next = '0;
    end
  end

  // Repeat counter and registered repeat strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt      <= rep_next;
      repeat_pulse <= repeat_next;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce (default parameters). Expected pulse events
// (cycle, kind) are queued as stimulus is applied and popped as the DUT
// emits strobes; level and reset values are checked at fixed cycles.
module tb_key_debounce;

  logic clk = 1'b0;
  logic reset;
  logic in_key;
  logic key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int edge_n = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  int exp_q[$];

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  key_debounce dut (
    .clk          (clk),
    .reset        (reset),
    .in_key       (in_key),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic push_ev(input int cyc, input int kind);
    exp_q.push_back(cyc * 4 + kind);
  endtask

  // Every strobe seen must be the next expected (cycle, kind) event.
  task automatic chk_pulse(input logic p, input int kind);
    int got;
    int expv;
    if (p !== 1'b0) begin
      got  = (p === 1'b1) ? edge_n * 4 + kind : -2;
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      n_cmp++;
      assert (got === expv) else begin
        n_bad++;
        $error("FAIL pulse: observed cycle %0d kind %0d, expected cycle %0d kind %0d",
               got / 4, got % 4, expv / 4, expv % 4);
      end
    end
  endtask

  always @(negedge clk) begin
    chk_pulse(press_pulse,   K_PRESS);
    chk_pulse(release_pulse, K_RELEASE);
    chk_pulse(long_pulse,    K_LONG);
    chk_pulse(repeat_pulse,  K_REPEAT);
  end

  task automatic goto_cyc(input int c);
    while (edge_n < c) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, edge_n, obs, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    in_key = 1'b0;

    // Reset values
    goto_cyc(2);
    check("rst_level",   key_level,     1'b0);
    check("rst_press",   press_pulse,   1'b0);
    check("rst_release", release_pulse, 1'b0);
    check("rst_long",    long_pulse,    1'b0);
    check("rst_repeat",  repeat_pulse,  1'b0);
    goto_cyc(3);
    reset = 1'b0;

    // Clean press at cycle 10, long press, clean release at cycle 40
    goto_cyc(9);
    in_key = 1'b1;
    push_ev(16, K_PRESS);
    push_ev(26, K_LONG);
`ifdef KEY_AUTO_REPEAT_EN
    push_ev(31, K_REPEAT);
    push_ev(36, K_REPEAT);
    push_ev(41, K_REPEAT);
`endif
    goto_cyc(15); check("press_level_before", key_level, 1'b0);
    goto_cyc(16); check("press_level_after",  key_level, 1'b1);
    goto_cyc(39);
    in_key = 1'b0;
    push_ev(46, K_RELEASE);
    goto_cyc(45); check("rel_level_before", key_level, 1'b1);
    goto_cyc(46); check("rel_level_after",  key_level, 1'b0);

    // Bounce: high 2, low 1, high 3, low
    goto_cyc(49); in_key = 1'b1;
    goto_cyc(51); in_key = 1'b0;
    goto_cyc(52); in_key = 1'b1;
    goto_cyc(55); in_key = 1'b0;
    goto_cyc(57); check("bounce_level_mid", key_level, 1'b0);
    goto_cyc(60); check("bounce_level_end", key_level, 1'b0);

    // Release glitch while held (press latency also confirms IDLE after bounce)
    goto_cyc(69);
    in_key = 1'b1;
    push_ev(76, K_PRESS);
    push_ev(89, K_LONG);
`ifdef KEY_AUTO_REPEAT_EN
    push_ev(94, K_REPEAT);
    push_ev(99, K_REPEAT);
`endif
    goto_cyc(76); check("glitch_press_level", key_level, 1'b1);
    goto_cyc(79); in_key = 1'b0;
    goto_cyc(81); in_key = 1'b1;
    goto_cyc(83); check("glitch_level_rw",   key_level, 1'b1);
    goto_cyc(85); check("glitch_level_held", key_level, 1'b1);
    goto_cyc(99);
    in_key = 1'b0;
    push_ev(106, K_RELEASE);
    goto_cyc(105); check("glitch_rel_before", key_level, 1'b1);
    goto_cyc(106); check("glitch_rel_after",  key_level, 1'b0);

    // Reset mid-hold with key still down
    goto_cyc(119);
    in_key = 1'b1;
    push_ev(126, K_PRESS);
    goto_cyc(127); check("hold_level", key_level, 1'b1);
    goto_cyc(129);
    reset = 1'b1;
    push_ev(137, K_PRESS);
    push_ev(147, K_LONG);
`ifdef KEY_AUTO_REPEAT_EN
    push_ev(152, K_REPEAT);
    push_ev(157, K_REPEAT);
`endif
    goto_cyc(130);
    reset = 1'b0;
    check("midrst_level",   key_level,     1'b0);
    check("midrst_release", release_pulse, 1'b0);
    check("midrst_press",   press_pulse,   1'b0);
    goto_cyc(136); check("repress_level_before", key_level, 1'b0);
    goto_cyc(137); check("repress_level_after",  key_level, 1'b1);
    goto_cyc(159);
    in_key = 1'b0;
    push_ev(166, K_RELEASE);
    goto_cyc(166); check("final_rel_level", key_level, 1'b0);

    // All expected events must have been consumed
    goto_cyc(180);
    n_cmp++;
    assert (exp_q.size() === 0) else begin
      n_bad++;
      $error("FAIL pending_events: observed %0d unconsumed, expected 0 (next cycle %0d kind %0d)",
             exp_q.size(), exp_q[0] / 4, exp_q[0] % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
